// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one input bit per clock.
// Valid/ready on both sides, optional signed input, overflow saturation and leading-zero flags.
module bin2bcd_seq #(
    parameter int unsigned W      = 13,
    parameter int unsigned D      = 4,
    parameter bit          SIGNED = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   bin,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [4*D-1:0] bcd,
    output logic           neg,
    output logic           ovf,
    output logic [D-1:0]   blank
);

    localparam int unsigned CW = $clog2(W + 1);

    function automatic logic [63:0] max_val(input int unsigned n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p - 64'd1;
    endfunction

    localparam logic [63:0] MaxVal = max_val(D);

    typedef enum logic [1:0] {Idle, Shift, Done} state_t;

    state_t         state;
    logic [4*D-1:0] digits;
    logic [W-1:0]   mag;
    logic [CW-1:0]  cnt;

    logic           bin_neg;
    logic [W-1:0]   mag_in;
    logic [4*D-1:0] adj;
    logic [4*D-1:0] nines;

    always_comb begin
        bin_neg = SIGNED && bin[W-1];
        // Two's-complement negate; -2^(W-1) maps to 2^(W-1) as unsigned.
        mag_in  = bin_neg ? (~bin + W'(1)) : bin;
        adj     = '0;
        nines   = '0;
        for (int k = 0; k < D; k++) begin
            adj[4*k +: 4]   = (digits[4*k +: 4] > 4'd4) ? digits[4*k +: 4] + 4'd3
                                                        : digits[4*k +: 4];
            nines[4*k +: 4] = 4'd9;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= Idle;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            digits    <= '0;
            mag       <= '0;
            cnt       <= '0;
            neg       <= 1'b0;
            ovf       <= 1'b0;
            bcd       <= '0;
        end else begin
            case (state)
                Idle: begin
                    if (in_valid) begin
                        mag      <= mag_in;
                        neg      <= bin_neg;
                        ovf      <= 64'(mag_in) > MaxVal;
                        digits   <= '0;
                        cnt      <= CW'(W);
                        in_ready <= 1'b0;
                        state    <= Shift;
                    end
                end
                Shift: begin
                    if (cnt != '0) begin
                        // Top bit of d[D-1] falls off; ovf already flags that case.
                        digits <= {adj[4*D-2:0], mag[W-1]};
                        mag    <= mag << 1;
                        cnt    <= cnt - CW'(1);
                    end else begin
                        bcd       <= ovf ? nines : digits;
                        out_valid <= 1'b1;
                        state     <= Done;
                    end
                end
                Done: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= Idle;
                    end
                end
                default: begin
                    state     <= Idle;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        logic zero;
        blank = '0;
        zero  = 1'b1;
        for (int k = D - 1; k >= 1; k--) begin
            zero     = zero && (bcd[4*k +: 4] == 4'd0);
            blank[k] = zero;
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: three configurations with hand-computed results.
module tb_bin2bcd_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // a: W=13 D=4 unsigned
    logic        a_iv = 1'b0, a_ir, a_ov, a_or = 1'b0, a_neg, a_ovf;
    logic [12:0] a_bin = '0;
    logic [15:0] a_bcd;
    logic [3:0]  a_blank;
    // b: W=13 D=3 unsigned
    logic        b_iv = 1'b0, b_ir, b_ov, b_or = 1'b0, b_neg, b_ovf;
    logic [12:0] b_bin = '0;
    logic [11:0] b_bcd;
    logic [2:0]  b_blank;
    // c: W=8 D=3 signed
    logic        c_iv = 1'b0, c_ir, c_ov, c_or = 1'b0, c_neg, c_ovf;
    logic [7:0]  c_bin = '0;
    logic [11:0] c_bcd;
    logic [2:0]  c_blank;

    bin2bcd_seq #(.W(13), .D(4), .SIGNED(1'b0)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .bin(a_bin),
        .out_valid(a_ov), .out_ready(a_or), .bcd(a_bcd), .neg(a_neg), .ovf(a_ovf),
        .blank(a_blank)
    );
    bin2bcd_seq #(.W(13), .D(3), .SIGNED(1'b0)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .bin(b_bin),
        .out_valid(b_ov), .out_ready(b_or), .bcd(b_bcd), .neg(b_neg), .ovf(b_ovf),
        .blank(b_blank)
    );
    bin2bcd_seq #(.W(8), .D(3), .SIGNED(1'b1)) dut_c (
        .clk(clk), .rst(rst), .in_valid(c_iv), .in_ready(c_ir), .bin(c_bin),
        .out_valid(c_ov), .out_ready(c_or), .bcd(c_bcd), .neg(c_neg), .ovf(c_ovf),
        .blank(c_blank)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept v, wait for out_valid (latency in cycles after accept edge), capture, consume.
    task automatic conv_a(input logic [12:0] v, output logic [15:0] b, output logic n,
                          output logic o, output logic [3:0] bl, output int lat);
        a_iv = 1'b1; a_bin = v;
        tick();
        a_iv = 1'b0;
        lat = 0;
        while (!a_ov && lat < 200) begin tick(); lat++; end
        checks++;
        if (a_ov !== 1'b1) begin
            errors++; $display("FAIL conv_a_timeout in=%0d out_valid=%b required 1", v, a_ov);
        end
        b = a_bcd; n = a_neg; o = a_ovf; bl = a_blank;
        a_or = 1'b1; tick(); a_or = 1'b0;
    endtask

    task automatic conv_b(input logic [12:0] v, output logic [11:0] b, output logic o);
        int lat;
        b_iv = 1'b1; b_bin = v;
        tick();
        b_iv = 1'b0;
        lat = 0;
        while (!b_ov && lat < 200) begin tick(); lat++; end
        checks++;
        if (b_ov !== 1'b1) begin
            errors++; $display("FAIL conv_b_timeout in=%0d out_valid=%b required 1", v, b_ov);
        end
        b = b_bcd; o = b_ovf;
        b_or = 1'b1; tick(); b_or = 1'b0;
    endtask

    task automatic conv_c(input logic [7:0] v, output logic [11:0] b, output logic n,
                          output logic [2:0] bl);
        int lat;
        c_iv = 1'b1; c_bin = v;
        tick();
        c_iv = 1'b0;
        lat = 0;
        while (!c_ov && lat < 200) begin tick(); lat++; end
        checks++;
        if (c_ov !== 1'b1) begin
            errors++; $display("FAIL conv_c_timeout in=%0h out_valid=%b required 1", v, c_ov);
        end
        b = c_bcd; n = c_neg; bl = c_blank;
        c_or = 1'b1; tick(); c_or = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        checks++;
        if ({a_ir, a_ov, a_bcd, a_neg, a_ovf, a_blank} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 4'b1110}) begin
            errors++;
            $display("FAIL reset_a got ir=%b ov=%b bcd=%h neg=%b ovf=%b blank=%b required 1 0 0000 0 0 1110",
                     a_ir, a_ov, a_bcd, a_neg, a_ovf, a_blank);
        end
        checks++;
        if ({c_ir, c_ov, c_bcd, c_neg, c_blank} !== {1'b1, 1'b0, 12'h0, 1'b0, 3'b110}) begin
            errors++;
            $display("FAIL reset_c got ir=%b ov=%b bcd=%h neg=%b blank=%b required 1 0 000 0 110",
                     c_ir, c_ov, c_bcd, c_neg, c_blank);
        end
    endtask

    task automatic test_max();
        logic [15:0] b; logic n, o; logic [3:0] bl; int lat;
        conv_a(13'd8191, b, n, o, bl, lat);
        checks++;
        if ({b, n, o, bl} !== {16'h8191, 1'b0, 1'b0, 4'b0000}) begin
            errors++;
            $display("FAIL max_8191 got bcd=%h neg=%b ovf=%b blank=%b required 8191 0 0 0000", b, n, o, bl);
        end
        checks++;
        if (lat != 14) begin
            errors++; $display("FAIL latency got %0d required 14", lat);
        end
    endtask

    task automatic test_blank();
        logic [15:0] b; logic n, o; logic [3:0] bl; int lat;
        conv_a(13'd0, b, n, o, bl, lat);
        checks++;
        if ({b, bl} !== {16'h0000, 4'b1110}) begin
            errors++; $display("FAIL zero got bcd=%h blank=%b required 0000 1110", b, bl);
        end
        conv_a(13'd42, b, n, o, bl, lat);
        checks++;
        if ({b, o, bl} !== {16'h0042, 1'b0, 4'b1100}) begin
            errors++; $display("FAIL val_42 got bcd=%h ovf=%b blank=%b required 0042 0 1100", b, o, bl);
        end
    endtask

    task automatic test_overflow();
        logic [11:0] b; logic o;
        conv_b(13'd1000, b, o);
        checks++;
        if ({b, o} !== {12'h999, 1'b1}) begin
            errors++; $display("FAIL ovf_1000 got bcd=%h ovf=%b required 999 1", b, o);
        end
        conv_b(13'd999, b, o);
        checks++;
        if ({b, o} !== {12'h999, 1'b0}) begin
            errors++; $display("FAIL ovf_999 got bcd=%h ovf=%b required 999 0", b, o);
        end
    endtask

    task automatic test_signed();
        logic [11:0] b; logic n; logic [2:0] bl;
        conv_c(8'h80, b, n, bl);
        checks++;
        if ({b, n} !== {12'h128, 1'b1}) begin
            errors++; $display("FAIL signed_80 got bcd=%h neg=%b required 128 1", b, n);
        end
        conv_c(8'h7F, b, n, bl);
        checks++;
        if ({b, n} !== {12'h127, 1'b0}) begin
            errors++; $display("FAIL signed_7f got bcd=%h neg=%b required 127 0", b, n);
        end
        conv_c(8'hFF, b, n, bl);
        checks++;
        if ({b, n, bl} !== {12'h001, 1'b1, 3'b110}) begin
            errors++; $display("FAIL signed_ff got bcd=%h neg=%b blank=%b required 001 1 110", b, n, bl);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] b; logic n, o; logic [3:0] bl; int lat;
        a_iv = 1'b1; a_bin = 13'd500;
        tick();
        a_iv = 1'b0;
        lat = 0;
        while (!a_ov && lat < 200) begin tick(); lat++; end
        a_iv = 1'b1; a_bin = 13'd77;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({a_ov, a_ir, a_bcd, a_ovf, a_neg} !== {1'b1, 1'b0, 16'h0500, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL hold_%0d got ov=%b ir=%b bcd=%h ovf=%b neg=%b required 1 0 0500 0 0",
                         i, a_ov, a_ir, a_bcd, a_ovf, a_neg);
            end
        end
        a_iv = 1'b0;
        a_or = 1'b1; tick(); a_or = 1'b0;
        checks++;
        if ({a_ir, a_ov} !== 2'b10) begin
            errors++; $display("FAIL release got ir=%b ov=%b required 1 0", a_ir, a_ov);
        end
        conv_a(13'd77, b, n, o, bl, lat);
        checks++;
        if ({b, bl} !== {16'h0077, 4'b1100}) begin
            errors++; $display("FAIL after_bp got bcd=%h blank=%b required 0077 1100", b, bl);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] b; logic n, o; logic [3:0] bl; int lat;
        a_iv = 1'b1; a_bin = 13'd4321;
        tick();
        a_iv = 1'b0;
        for (int i = 0; i < 7; i++) tick();   // counter now 13-7 = 6
        rst = 1'b1; tick(); rst = 1'b0;
        checks++;
        if ({a_ir, a_ov, a_bcd} !== {1'b1, 1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL mid_reset got ir=%b ov=%b bcd=%h required 1 0 0000", a_ir, a_ov, a_bcd);
        end
        conv_a(13'd1234, b, n, o, bl, lat);
        checks++;
        if ({b, o, lat} !== {16'h1234, 1'b0, 32'd14}) begin
            errors++; $display("FAIL post_reset got bcd=%h ovf=%b lat=%0d required 1234 0 14", b, o, lat);
        end
    endtask

    initial begin
        test_reset();
        test_max();
        test_blank();
        test_overflow();
        test_signed();
        test_backpressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
